pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Drives the `pc` input of the single-cycle datapath top, so the datapath no longer needs an externally supplied program counter.
- Observes the fetched instruction and the two register-file read ports, and computes the next PC for sequential flow, beq, bne and j.
- Detects a halt word or an out-of-range PC, counts retired instructions, and supports free-run and single-step execution.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on every start.
- PC_LIMIT, 32'h0000_03FC, highest legal fetch address (inclusive).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops execution.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins execution from RESET_PC.
- step_mode  input  1  1 = advance only on step pulses; 0 = advance every cycle.
- step  input  1  single-step pulse; ignored when step_mode=0.
- instruction  input  32  word fetched from instruction memory at the current pc (combinational).
- rs_data  input  32  register-file read port 1 (out1).
- rt_data  input  32  register-file read port 2 (out2).
- pc  output  32  current fetch address.
- running  output  1  high while in RUN.
- halted  output  1  high in HALT.
- fault  output  1  high when HALT was entered through the PC-limit check.
- retired  output  CNT_W  count of PC advances since the last start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, running=0, halted=0, fault=0, retired=0.
  - Reset is effective mid-RUN with no completion of the current instruction.
- States:
  - IDLE → RUN on start. pc is reloaded to RESET_PC on that edge.
  - RUN → HALT on halt word or limit violation.
  - HALT → RUN on start, with pc=RESET_PC and retired=0, fault=0 on the same edge.
  - start is ignored while in RUN.
- Advance condition in RUN: adv = (step_mode==0) | step. When adv=0, pc and retired hold.
- Next-PC computation when adv=1, using pc4 = pc+4 (mod 2^32) and opcode = instruction[31:26]:
  - instruction==HALT_WORD: no advance; → HALT, pc holds, retired unchanged. This check has priority over all decode.
  - opcode 000100 (beq): if rs_data==rt_data, npc = pc4 + ({{14{imm[15]}},imm,2'b00}); otherwise npc = pc4.
  - opcode 000101 (bne): the inverse condition of beq.
  - opcode 000010 (j): npc = {pc4[31:28], instruction[25:0], 2'b00}.
  - All other opcodes: npc = pc4.
- Limit check:
  - If npc > PC_LIMIT (unsigned), or npc wraps past 32'hFFFF_FFFC: → HALT, fault=1, pc holds at the faulting instruction, retired does not increment.
  - Otherwise pc <= npc and retired <= retired+1, saturating at all-ones.
- Branch offset arithmetic is 32-bit modular. Targets are always word-aligned by construction.
- Latency: one clock per instruction. pc updates on the rising edge after the instruction is presented.
- step held high for N cycles in step_mode advances N instructions; it is level-qualified each cycle.
- step_mode may change at any time and takes effect on the next edge.
- Outputs are registered (running, halted and fault decode the state register directly). No combinational path from start or step to pc.

Test Plan:
- Reset then start with a straight-line program of 3 adds followed by HALT_WORD at 0x0C → pc steps 0,4,8,C. After that, halted=1, pc=0x0C, retired=3, fault=0.
- beq at 0x04 with imm=16'h0003 and rs_data=rt_data=5 → pc 0x04→0x14, retired+1. Repeat with rs_data≠rt_data → pc 0x04→0x08. Repeat with bne → outcomes inverted.
- beq at 0x10 with imm=16'hFFFC and equal operands → pc 0x10→0x04 (backward branch). j at 0x08 with target 26'h40 → pc=0x100.
- j with target 26'h3FF at PC_LIMIT=0x3FC → npc=0xFFC: halted=1, fault=1, pc holds at 0x08 (the address of the j), retired unchanged.
- step_mode=1 with step pulsed at cycles 2 and 5 after start → pc changes only on those two edges, retired=2. Then toggle step_mode=0 → pc advances every cycle.
- Deassert rst_n asynchronously mid-RUN at pc=0x20 → pc=0 and running=0 immediately without waiting for a clock edge. Also check that start while in RUN is ignored, and that start while in HALT restarts at RESET_PC with retired=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control/observation bundle between the PC sequencer and its datapath/host.
// Master drives start/step controls and the fetched instruction and operands; slave returns PC and status.
interface pc_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             step_mode;
   logic             step;
   logic [31:0]      instruction;
   logic [31:0]      rs_data;
   logic [31:0]      rt_data;
   logic [31:0]      pc;
   logic             running;
   logic             halted;
   logic             fault;
   logic [CNT_W-1:0] retired;

   modport master (
      output start, step_mode, step, instruction, rs_data, rt_data,
      input  pc, running, halted, fault, retired
   );

   modport slave (
      input  start, step_mode, step, instruction, rs_data, rt_data,
      output pc, running, halted, fault, retired
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/beq/bne/j next-PC, halt-word and PC-limit stop,
// retired-instruction count, free-run or single-step advance.
//
// state   | meaning
// S_IDLE  | out of reset, waiting for start
// S_RUN   | fetching; pc advances on every qualified cycle
// S_HALT  | stopped on the halt word
// S_FAULT | stopped because next pc left the legal fetch window
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT  = 32'h0000_03FC,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int          CNT_W     = 16
) (
   input logic             clk,
   input logic             rst_n,
   pc_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [5:0]  opcode;
   logic [32:0] pc4_w;
   logic [31:0] br_off;
   logic [31:0] npc;
   logic        take;
   logic        adv;
   logic        limit_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

   // Next-PC decode; the carry out of pc+4 marks a wrap past the top of the address space.
   always_comb begin
      opcode = bus.instruction[31:26];
      pc4_w  = {1'b0, pc_q} + 33'd4;
      br_off = {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
      take   = 1'b0;
      npc    = pc4_w[31:0];
      case (opcode)
         OP_BEQ:  take = (bus.rs_data == bus.rt_data);
         OP_BNE:  take = (bus.rs_data != bus.rt_data);
         default: take = 1'b0;
      endcase
      if (opcode == OP_J)
         npc = {pc4_w[31:28], bus.instruction[25:0], 2'b00};
      else if (take)
         npc = pc4_w[31:0] + br_off;
      limit_hit = pc4_w[32] | (npc > PC_LIMIT);
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      adv       = !bus.step_mode || bus.step;
      case (state_q)
         S_RUN: begin
            if (adv) begin
               if (bus.instruction == HALT_WORD) begin
                  state_d = S_HALT;
               end else if (limit_hit) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d      = npc;
                  retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;
               end
            end
         end
         default: begin
            if (bus.start) begin
               state_d   = S_RUN;
               pc_d      = RESET_PC;
               retired_d = '0;
            end
         end
      endcase
   end

   assign bus.pc      = pc_q;
   assign bus.retired = retired_q;
   assign bus.running = (state_q == S_RUN);
   assign bus.halted  = (state_q == S_HALT) || (state_q == S_FAULT);
   assign bus.fault   = (state_q == S_FAULT);
endmodule
